// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Hardwired Moore control sequencer for the bus-based datapath. It fetches an
// instruction in three states (T0-T2) through PC/MAR/MDR/IR, decodes the IR
// value fed back from the datapath, and then walks up to five execute states
// (T3-T7) that depend on the instruction class. A halt instruction parks the
// sequencer in HALT until clear is asserted.
//
// Every output is a combinational function of the state register and `ir`.
// While clear is high, every output, including run, is held at 0.
//
// Optional feature macro:
//   CU_MULDIV_EN  defined   -> mul (10000) / div (01111) run their 4-step
//                              execute sequence (Y, Z, LO, HI captures).
//                 undefined -> both opcodes decode as nop; HIin/LOin are
//                              never asserted. mfhi/mflo still operate.
//
// Ports:
//   clock        in   system clock, all state changes on the rising edge
//   clear        in   synchronous active-high reset (next state T0)
//   ir[31:0]     in   datapath IR: op[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   Rin[15:0]    out  one-hot GPR write enables (bit n -> Rn)
//   Rout[15:0]   out  one-hot GPR bus-drive enables (bit n -> Rn)
//   HIin/HIout, LOin/LOout, Zin, Zhighout, Zlowout, Yin           out
//   MDRin, MDRout, MARin, PCin, PCout, IRin, IncPC, Cout,
//   InPortout, Out_portIn                                          out
//   read         out  memory read strobe (also MDR input mux select)
//   RAMwrite     out  memory write strobe
//   alu_op[4:0]  out  ALU opcode
//   run          out  high while sequencing; low in HALT or during clear
// ---------------------------------------------------------------------------
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        Yin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        PCout,
    output logic        IRin,
    output logic        IncPC,
    output logic        Cout,
    output logic        InPortout,
    output logic        Out_portIn,
    output logic        read,
    output logic        RAMwrite,
    output logic [4:0]  alu_op,
    output logic        run
);

`ifdef CU_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    // Opcodes
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd8
    } state_t;

    state_t state;

    // IR fields
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;

    assign op = ir[31:27];
    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];

    // Instruction classes
    logic is_alu;
    logic is_imm;
    logic is_ld;
    logic is_st;
    logic is_mem;
    logic is_muldiv;
    logic is_halt;

    assign is_alu    = (op >= OP_ADD) && (op <= OP_SHL);
    assign is_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
    assign is_ld     = (op == OP_LD);
    assign is_st     = (op == OP_ST);
    assign is_mem    = is_ld || is_st;
    assign is_muldiv = MULDIV_EN && ((op == OP_MUL) || (op == OP_DIV));
    assign is_halt   = (op == OP_HALT);

    function automatic logic [15:0] reg_sel(input logic [3:0] n);
        reg_sel = 16'h0001 << n;
    endfunction

    // -----------------------------------------------------------------------
    // State sequencing. clear overrides everything, including HALT.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= T0;
        end else begin
            case (state)
                T0: state <= T1;
                T1: state <= T2;
                T2: state <= T3;
                T3: begin
                    if (is_halt)
                        state <= HALT;
                    else if (is_alu || is_imm || is_mem || is_muldiv)
                        state <= T4;
                    else
                        state <= T0;
                end
                T4: state <= T5;
                T5: begin
                    if (is_mem || is_muldiv)
                        state <= T6;
                    else
                        state <= T0;
                end
                T6: begin
                    if (is_mem)
                        state <= T7;
                    else
                        state <= T0;
                end
                T7:      state <= T0;
                HALT:    state <= HALT;
                default: state <= T0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Strobe decode. Everything defaults to 0; the clear gate wraps the whole
    // decode so no strobe can leak out while reset is sampled.
    // -----------------------------------------------------------------------
    always_comb begin
        Rin        = 16'h0000;
        Rout       = 16'h0000;
        HIin       = 1'b0;
        HIout      = 1'b0;
        LOin       = 1'b0;
        LOout      = 1'b0;
        Zin        = 1'b0;
        Zhighout   = 1'b0;
        Zlowout    = 1'b0;
        Yin        = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        PCin       = 1'b0;
        PCout      = 1'b0;
        IRin       = 1'b0;
        IncPC      = 1'b0;
        Cout       = 1'b0;
        InPortout  = 1'b0;
        Out_portIn = 1'b0;
        read       = 1'b0;
        RAMwrite   = 1'b0;
        alu_op     = 5'b00000;
        run        = 1'b0;

        if (!clear) begin
            run = (state != HALT);
            case (state)
                T0: begin
                    PCout = 1'b1;
                    MARin = 1'b1;
                    IncPC = 1'b1;
                    Zin   = 1'b1;
                end
                T1: begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                    read    = 1'b1;
                    MDRin   = 1'b1;
                end
                T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                T3: begin
                    if (is_alu || is_imm || is_mem) begin
                        Rout = reg_sel(rb);
                        Yin  = 1'b1;
                    end else if (is_muldiv) begin
                        // mul/div latch Ra into Y, Rb goes through the bus next
                        Rout = reg_sel(ra);
                        Yin  = 1'b1;
                    end else begin
                        case (op)
                            OP_MFHI: begin
                                HIout = 1'b1;
                                Rin   = reg_sel(ra);
                            end
                            OP_MFLO: begin
                                LOout = 1'b1;
                                Rin   = reg_sel(ra);
                            end
                            OP_JR: begin
                                Rout = reg_sel(ra);
                                PCin = 1'b1;
                            end
                            OP_IN: begin
                                InPortout = 1'b1;
                                Rin       = reg_sel(ra);
                            end
                            OP_OUT: begin
                                Rout       = reg_sel(ra);
                                Out_portIn = 1'b1;
                            end
                            default: ;  // nop, halt, unused opcodes
                        endcase
                    end
                end
                T4: begin
                    if (is_alu) begin
                        Rout   = reg_sel(rc);
                        alu_op = op;
                        Zin    = 1'b1;
                    end else if (is_imm) begin
                        Cout   = 1'b1;
                        alu_op = op;
                        Zin    = 1'b1;
                    end else if (is_mem) begin
                        // effective address = Rb + C, always an add
                        Cout   = 1'b1;
                        alu_op = OP_ADD;
                        Zin    = 1'b1;
                    end else if (is_muldiv) begin
                        Rout   = reg_sel(rb);
                        alu_op = op;
                        Zin    = 1'b1;
                    end
                end
                T5: begin
                    if (is_alu || is_imm) begin
                        Zlowout = 1'b1;
                        Rin     = reg_sel(ra);
                    end else if (is_mem) begin
                        Zlowout = 1'b1;
                        MARin   = 1'b1;
                    end else if (is_muldiv) begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                end
                T6: begin
                    if (is_ld) begin
                        read  = 1'b1;
                        MDRin = 1'b1;
                    end else if (is_st) begin
                        // read low selects the bus into MDR
                        Rout  = reg_sel(ra);
                        MDRin = 1'b1;
                    end else if (is_muldiv) begin
                        Zhighout = 1'b1;
                        HIin     = 1'b1;
                    end
                end
                T7: begin
                    if (is_ld) begin
                        MDRout = 1'b1;
                        Rin    = reg_sel(ra);
                    end else if (is_st) begin
                        RAMwrite = 1'b1;
                    end
                end
                default: ;  // HALT: no strobes
            endcase
        end
    end

endmodule
